usb_rx_ctrl: RTL and testbench
==============================

Name: usb_rx_ctrl

Overview:
- Parametrised next-generation receiver control unit for the USB bulk-endpoint RX path.
- Sequences SYNC, PID, payload, EOP and CRC verdict for token, data and handshake packets.
- Enforces PID check-nibble, per-class length rules and an inactivity timeout, and reports a coded error.
- Sits between the byte assembler / EOP detector / CRC checkers and the RX FIFO / protocol layer.

Parameters:
- MAX_PAYLOAD, 64, maximum data-packet payload bytes, excluding the 2 CRC16 bytes.
- TIMEOUT_CYCLES, 1024, clocks without byte_complete or eop before a timeout error.
- CNT_W, $clog2(MAX_PAYLOAD+3), width of data_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- d_edge  in  1  first line transition seen while bus idle
- byte_complete  in  1  one-cycle strobe; rx_byte valid
- rx_byte  in  8  assembled byte, bit 0 first on wire
- eop  in  1  one-cycle end-of-packet strobe
- crc_valid  in  1  CRC checker verdict ready
- crc_ok  in  1  verdict; sampled only with crc_valid
- enable_timer  out  1  bit-timer enable for the byte assembler
- crc_clear  out  1  one-cycle CRC checker reset pulse
- crc_sel  out  1  0 = CRC5 (token), 1 = CRC16 (data)
- load_pid  out  1  one-cycle pulse; pid valid
- pid  out  4  registered PID nibble
- load_data  out  1  pulse; forward rx_byte downstream
- data_count  out  CNT_W  bytes received in the data phase, including CRC bytes
- load_done  out  1  one-cycle packet-good pulse
- load_error  out  1  one-cycle packet-bad pulse
- err_code  out  3  registered; valid from load_error until the next packet start
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: state = IDLE; pid = 0, data_count = 0, err_code = 0; all pulse outputs, enable_timer and busy = 0. A reset mid-packet aborts the packet with no pulse.
- Error codes: 0 none, 1 SYNC, 2 PID check, 3 unsupported PID, 4 length, 5 CRC, 6 timeout.
- Timeout counter: clears on byte_complete, on eop and on every state change. Active in SYNC, PID, TOKEN, DATA, HSK and CHECK. Reaching TIMEOUT_CYCLES-1 forces ERROR with code 6.
- IDLE: on d_edge go to SYNC. In that transition cycle crc_clear = 1, and err_code and data_count are cleared.
- SYNC: enable_timer = 1. On byte_complete, rx_byte == 8'h80 goes to PID; any other byte goes to ERROR with code 1. eop goes to ERROR with code 1.
- PID: on byte_complete, if rx_byte[7:4] != ~rx_byte[3:0] go to ERROR with code 2. Otherwise register pid and pulse load_pid (registered output, one cycle after the strobe). Then branch on the PID:
  - OUT/IN/SETUP (0x1, 0x9, 0xD) go to TOKEN with crc_sel = 0.
  - DATA0/DATA1 (0x3, 0xB) go to DATA with crc_sel = 1.
  - ACK/NAK/STALL (0x2, 0xA, 0xE) go to HSK.
  - Any other PID goes to ERROR with code 3.
  - eop in PID goes to ERROR with code 4.
- TOKEN: counts bytes internally. On eop, exactly 2 bytes go to CHECK; any other count goes to ERROR with code 4. A 3rd byte goes to ERROR with code 4 immediately.
- DATA: load_data = byte_complete (combinational, same cycle); data_count increments per byte. A byte arriving when data_count == MAX_PAYLOAD+2 goes to ERROR with code 4, and load_data is suppressed for it. On eop, data_count < 2 goes to ERROR with code 4; otherwise go to CHECK.
- HSK: eop goes to DONE. Any byte goes to ERROR with code 4.
- Simultaneous byte_complete and eop: the byte is counted and forwarded first, then the eop rules are applied to the updated count, all in the same cycle.
- CHECK: enable_timer = 0. On crc_valid, crc_ok = 1 goes to DONE; crc_ok = 0 goes to ERROR with code 5.
- ERROR: load_error = 1 for one cycle and err_code is registered.
  - If eop was already seen, go to IDLE.
  - Otherwise go to DRAIN.
- DRAIN: ignores bytes; eop or timeout goes to IDLE. No second load_error.
- DONE: load_done = 1 for one cycle, then go to IDLE.
- d_edge is ignored outside IDLE.
- Latency: d_edge to crc_clear is 0 cycles. Final eop to load_done is 1 cycle for HSK and at least 2 cycles for CHECK (one extra cycle per cycle of crc_valid wait).

Optional Feature:
- Macro: USB_RX_STATS_EN.
- Defined: adds output ports pkt_count[15:0] and err_count[15:0]. pkt_count increments on load_done, err_count on load_error. Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package usb_rx_pkg holds:
  - the PID enum (4-bit values above);
  - the state enum: IDLE, SYNC, PID, TOKEN, DATA, HSK, CHECK, ERROR, DRAIN, DONE;
  - the err_code enum;
  - the constant SYNC_BYTE = 8'h80.
- Sub-module rx_timeout_timer (parameter TIMEOUT_CYCLES; inputs clear and enable; output expired) implements the timeout counter.

Test Plan:
- d_edge, 0x80, 0xE1 (OUT), 2 bytes, eop, crc_valid with crc_ok = 1 -> load_pid with pid = 0x1, crc_sel = 0, load_done 2 cycles after eop, err_code = 0.
- 0x80, 0xC3 (DATA0), 5 payload + 2 CRC bytes, eop, crc_ok = 0 -> 7 load_data pulses, data_count = 7, load_error with err_code = 5.
- 0x80, 0xD2 (ACK), eop -> load_done 1 cycle after eop; no load_data. Repeat with 0xD3 -> err_code = 2 then DRAIN until eop.
- DATA1 with MAX_PAYLOAD+3 bytes -> load_error with err_code = 4 on the 67th byte, 66 load_data pulses, DRAIN until eop, then IDLE.
- Stall after the PID for TIMEOUT_CYCLES clocks -> load_error with err_code = 6, return to IDLE. Separately, assert rst mid-DATA -> all outputs 0 immediately, no pulse.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB bulk-endpoint RX control path.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_e;

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, TOKEN, DATA, HSK, CHECK, ERROR, DRAIN, DONE
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SYNC    = 3'd1,
    ERR_PID     = 3'd2,
    ERR_UNSUP   = 3'd3,
    ERR_LEN     = 3'd4,
    ERR_CRC     = 3'd5,
    ERR_TIMEOUT = 3'd6
  } err_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inactivity timer: counts enabled cycles since the last clear, flags expiry.
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign expired = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || !enable) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB RX control FSM: sequences SYNC/PID/payload/EOP/CRC and reports coded errors.
// Optional USB_RX_STATS_EN adds saturating packet/error counters.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = $clog2(MAX_PAYLOAD + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             byte_complete,
  input  logic [7:0]       rx_byte,
  input  logic             eop,
  input  logic             crc_valid,
  input  logic             crc_ok,
  output logic             enable_timer,
  output logic             crc_clear,
  output logic             crc_sel,
  output logic             load_pid,
  output logic [3:0]       pid,
  output logic             load_data,
  output logic [CNT_W-1:0] data_count,
  output logic             load_done,
  output logic             load_error,
  output logic [2:0]       err_code,
  output logic             busy
`ifdef USB_RX_STATS_EN
  ,
  output logic [15:0]      pkt_count,
  output logic [15:0]      err_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PAYLOAD + 2);

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_e             err_q, err_d;
  logic             load_pid_q, load_pid_d;
  logic             crc_sel_q, crc_sel_d;
  logic [1:0]       tok_q, tok_d;
  logic             eop_seen_q, eop_seen_d;
  logic             timer_en, timer_clr, expired;

  assign timer_en  = state_q inside {SYNC, PID, TOKEN, DATA, HSK, CHECK, DRAIN};
  assign timer_clr = byte_complete | eop | (state_d != state_q);

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pid_q      <= '0;
      cnt_q      <= '0;
      err_q      <= ERR_NONE;
      load_pid_q <= 1'b0;
      crc_sel_q  <= 1'b0;
      tok_q      <= '0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      load_pid_q <= load_pid_d;
      crc_sel_q  <= crc_sel_d;
      tok_q      <= tok_d;
      eop_seen_q <= eop_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    load_pid_d = 1'b0;
    crc_sel_d  = crc_sel_q;
    tok_d      = tok_q;
    eop_seen_d = eop_seen_q | eop;

    unique case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d    = SYNC;
          cnt_d      = '0;
          err_d      = ERR_NONE;
          tok_d      = '0;
          eop_seen_d = 1'b0;
        end
      end
      SYNC: begin
        if (byte_complete && rx_byte == SYNC_BYTE) begin
          state_d = PID;
        end else if (byte_complete || eop) begin
          state_d = ERROR;
          err_d   = ERR_SYNC;
        end
      end
      PID: begin
        if (byte_complete) begin
          if (!pid_check_ok(rx_byte)) begin
            state_d = ERROR;
            err_d   = ERR_PID;
          end else begin
            pid_d      = rx_byte[3:0];
            load_pid_d = 1'b1;
            case (rx_byte[3:0])
              PID_OUT, PID_IN, PID_SETUP: begin
                state_d   = TOKEN;
                crc_sel_d = 1'b0;
              end
              PID_DATA0, PID_DATA1: begin
                state_d   = DATA;
                crc_sel_d = 1'b1;
              end
              PID_ACK, PID_NAK, PID_STALL: state_d = HSK;
              default: begin
                state_d = ERROR;
                err_d   = ERR_UNSUP;
              end
            endcase
          end
        end
        if (eop && state_d != ERROR) begin
          state_d = ERROR;
          err_d   = ERR_LEN;
        end
      end
      // Byte is accounted first; eop then judges the updated count.
      TOKEN: begin
        if (byte_complete) begin
          if (tok_q == 2'd2) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            tok_d = tok_q + 2'd1;
          end
        end
        if (eop && state_d != ERROR) begin
          if (tok_d == 2'd2) begin
            state_d = CHECK;
          end else begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end
        end
      end
      DATA: begin
        if (byte_complete) begin
          if (cnt_q == CNT_LIMIT) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (eop && state_d != ERROR) begin
          if (cnt_d < CNT_W'(2)) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d = CHECK;
          end
        end
      end
      HSK: begin
        if (byte_complete) begin
          state_d = ERROR;
          err_d   = ERR_LEN;
        end else if (eop) begin
          state_d = DONE;
        end
      end
      CHECK: begin
        if (crc_valid) begin
          if (crc_ok) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_CRC;
          end
        end
      end
      ERROR:   state_d = (eop_seen_q || eop) ? IDLE : DRAIN;
      DRAIN:   if (eop || expired) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timeout only wins when no other event moved the FSM this cycle.
    if (expired && state_d == state_q && !byte_complete && !eop &&
        state_q inside {SYNC, PID, TOKEN, DATA, HSK, CHECK}) begin
      state_d = ERROR;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_comb begin
    enable_timer = 1'b0;
    crc_clear    = 1'b0;
    load_data    = 1'b0;
    load_done    = 1'b0;
    load_error   = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE:  crc_clear = d_edge;
      SYNC, PID, TOKEN, HSK: enable_timer = 1'b1;
      DATA: begin
        enable_timer = 1'b1;
        load_data    = byte_complete && (cnt_q != CNT_LIMIT);
      end
      ERROR: load_error = 1'b1;
      DONE:  load_done  = 1'b1;
      default: ;
    endcase
  end

  assign pid        = pid_q;
  assign data_count = cnt_q;
  assign err_code   = err_q;
  assign load_pid   = load_pid_q;
  assign crc_sel    = crc_sel_q;

`ifdef USB_RX_STATS_EN
  logic [15:0] pkt_q, errc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      errc_q <= '0;
    end else begin
      if (state_q == DONE && pkt_q != '1)   pkt_q  <= pkt_q + 16'd1;
      if (state_q == ERROR && errc_q != '1) errc_q <= errc_q + 16'd1;
    end
  end

  assign pkt_count = pkt_q;
  assign err_count = errc_q;
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed self-checking bench for usb_rx_ctrl: packet vector table plus corner sequences.
module tb_usb_rx_ctrl;

  localparam int MAXP = 64;
  localparam int TMO  = 1024;
  localparam int CW   = $clog2(MAXP + 3);
  localparam int NV   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          d_edge = 1'b0, byte_complete = 1'b0, eop = 1'b0;
  logic          crc_valid = 1'b0, crc_ok = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          enable_timer, crc_clear, crc_sel, load_pid, load_data;
  logic          load_done, load_error, busy;
  logic [3:0]    pid;
  logic [CW-1:0] data_count;
  logic [2:0]    err_code;
`ifdef USB_RX_STATS_EN
  logic [15:0]   pkt_count, err_count;
`endif

  always #5 clk = ~clk;

  usb_rx_ctrl #(
    .MAX_PAYLOAD   (MAXP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .byte_complete(byte_complete),
    .rx_byte      (rx_byte),
    .eop          (eop),
    .crc_valid    (crc_valid),
    .crc_ok       (crc_ok),
    .enable_timer (enable_timer),
    .crc_clear    (crc_clear),
    .crc_sel      (crc_sel),
    .load_pid     (load_pid),
    .pid          (pid),
    .load_data    (load_data),
    .data_count   (data_count),
    .load_done    (load_done),
    .load_error   (load_error),
    .err_code     (err_code),
    .busy         (busy)
`ifdef USB_RX_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .err_count    (err_count)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] sync;
    logic [7:0] pid_byte;
    int         nbytes;
    logic       crc_ok;
    logic       use_crc;
    logic       exp_done;
    int         exp_code;
    int         exp_npid;
    int         exp_pid;
    logic       chk_sel;
    logic       exp_sel;
    int         exp_ndata;
    int         exp_count;
    int         exp_lat;   // pulse cycle minus eop cycle
    int         exp_idle;  // first cycle after eop with busy low
  } vec_t;

  vec_t vecs [NV];

  int n_tests = 0, n_fail = 0;
  int cyc, n_data, n_pid, n_done, n_err, n_clr, done_cyc, err_cyc, clr_cyc;
  logic [3:0] got_pid;
  logic got_sel, s_busy, s_en;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr_mon();
    cyc = 0; n_data = 0; n_pid = 0; n_done = 0; n_err = 0; n_clr = 0;
    done_cyc = -1000; err_cyc = -1000; clr_cyc = -1000;
    got_pid = '0; got_sel = 1'b0; s_busy = 1'b0; s_en = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge, release after the next posedge.
  task automatic step(input logic de, input logic bc, input logic [7:0] b,
                      input logic e, input logic cv, input logic co);
    d_edge = de; byte_complete = bc; rx_byte = b; eop = e; crc_valid = cv; crc_ok = co;
    @(negedge clk);
    cyc++;
    if (load_data) n_data++;
    if (load_pid) begin n_pid++; got_pid = pid; got_sel = crc_sel; end
    if (load_done) begin n_done++; done_cyc = cyc; end
    if (load_error) begin n_err++; err_cyc = cyc; end
    if (crc_clear) begin n_clr++; clr_cyc = cyc; end
    s_busy = busy;
    s_en   = enable_timer;
    @(posedge clk);
    #1;
    d_edge = 1'b0; byte_complete = 1'b0; rx_byte = 8'h00; eop = 1'b0;
    crc_valid = 1'b0; crc_ok = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int eop_cyc, idle_rel, en_chk, ref_cyc;

    vecs[0]  = '{"out_ok",       8'h80, 8'hE1, 2, 1'b1, 1'b1, 1'b1, 0, 1, 1,  1'b1, 1'b0, 0, 0,  2, 3};
    vecs[1]  = '{"data0_crcbad", 8'h80, 8'hC3, 7, 1'b0, 1'b1, 1'b0, 5, 1, 3,  1'b1, 1'b1, 7, 7,  2, 3};
    vecs[2]  = '{"ack",          8'h80, 8'hD2, 0, 1'b0, 1'b0, 1'b1, 0, 1, 2,  1'b0, 1'b0, 0, 0,  1, 2};
    vecs[3]  = '{"pid_chk",      8'h80, 8'hD3, 2, 1'b0, 1'b0, 1'b0, 2, 0, 0,  1'b0, 1'b0, 0, 0, -2, 1};
    vecs[4]  = '{"in_short",     8'h80, 8'h69, 1, 1'b0, 1'b0, 1'b0, 4, 1, 9,  1'b1, 1'b0, 0, 0,  1, 2};
    vecs[5]  = '{"setup_long",   8'h80, 8'h2D, 3, 1'b0, 1'b0, 1'b0, 4, 1, 13, 1'b1, 1'b0, 0, 0,  0, 1};
    vecs[6]  = '{"data1_short",  8'h80, 8'h4B, 1, 1'b0, 1'b0, 1'b0, 4, 1, 11, 1'b1, 1'b1, 1, 1,  1, 2};
    vecs[7]  = '{"data1_min",    8'h80, 8'h4B, 2, 1'b1, 1'b1, 1'b1, 0, 1, 11, 1'b1, 1'b1, 2, 2,  2, 3};
    vecs[8]  = '{"nak_byte",     8'h80, 8'h5A, 1, 1'b0, 1'b0, 1'b0, 4, 1, 10, 1'b0, 1'b0, 0, 0,  0, 1};
    vecs[9]  = '{"unsup_pid",    8'h80, 8'hF0, 0, 1'b0, 1'b0, 1'b0, 3, 1, 0,  1'b0, 1'b0, 0, 0,  0, 1};
    vecs[10] = '{"stall",        8'h80, 8'h1E, 0, 1'b0, 1'b0, 1'b1, 0, 1, 14, 1'b0, 1'b0, 0, 0,  1, 2};
    vecs[11] = '{"bad_sync",     8'h40, 8'hE1, 0, 1'b0, 1'b0, 1'b0, 1, 0, 0,  1'b0, 1'b0, 0, 0, -1, 1};

    clr_mon();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs", int'({busy, load_data, load_pid, load_done, load_error, crc_clear,
                               crc_sel, enable_timer, pid, err_code, data_count}), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      clr_mon();
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, vecs[i].sync, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, vecs[i].pid_byte, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < vecs[i].nbytes; j++)
        step(1'b0, 1'b1, 8'(8'hA0 + j), 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      eop_cyc  = cyc;
      idle_rel = -1;
      en_chk   = -1;
      for (int k = 1; k <= 40; k++) begin
        step(1'b0, 1'b0, 8'h00, 1'b0, k == 1, vecs[i].crc_ok);
        if (k == 1) en_chk = int'(s_en);
        if (!s_busy) begin
          idle_rel = k;
          break;
        end
      end
      chk({vecs[i].name, "_done"},  n_done, int'(vecs[i].exp_done));
      chk({vecs[i].name, "_error"}, n_err, int'(!vecs[i].exp_done));
      chk({vecs[i].name, "_code"},  int'(err_code), vecs[i].exp_code);
      chk({vecs[i].name, "_npid"},  n_pid, vecs[i].exp_npid);
      if (vecs[i].exp_npid > 0) chk({vecs[i].name, "_pid"}, int'(got_pid), vecs[i].exp_pid);
      if (vecs[i].chk_sel) chk({vecs[i].name, "_crcsel"}, int'(got_sel), int'(vecs[i].exp_sel));
      chk({vecs[i].name, "_ndata"}, n_data, vecs[i].exp_ndata);
      chk({vecs[i].name, "_count"}, int'(data_count), vecs[i].exp_count);
      chk({vecs[i].name, "_latency"},
          (vecs[i].exp_done ? done_cyc : err_cyc) - eop_cyc, vecs[i].exp_lat);
      chk({vecs[i].name, "_idle"}, idle_rel, vecs[i].exp_idle);
      chk({vecs[i].name, "_crcclr_n"}, n_clr, 1);
      chk({vecs[i].name, "_crcclr_cyc"}, clr_cyc, 1);
      if (vecs[i].use_crc) chk({vecs[i].name, "_check_timer_off"}, en_chk, 0);
    end

    // DATA1 overflow: the 67th byte errors, two more are drained, then eop.
    clr_mon();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);
    ref_cyc = 0;
    for (int j = 1; j <= MAXP + 5; j++) begin
      step(1'b0, 1'b1, 8'(j), 1'b0, 1'b0, 1'b0);
      if (j == MAXP + 3) ref_cyc = cyc;
    end
    chk("ovf_drain_busy", int'(s_busy), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ovf_idle_after_eop", int'(s_busy), 0);
    chk("ovf_ndata", n_data, MAXP + 2);
    chk("ovf_count", int'(data_count), MAXP + 2);
    chk("ovf_nerr", n_err, 1);
    chk("ovf_err_cycle", err_cyc - ref_cyc, 1);
    chk("ovf_code", int'(err_code), 4);
    chk("ovf_ndone", n_done, 0);

    // Stall after an OUT PID: timeout error, then drain also times out.
    clr_mon();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    chk("tmo_sync_timer_on", int'(s_en), 1);
    step(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    ref_cyc = cyc;
    for (int k = 0; k < TMO + 100 && n_err == 0; k++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("tmo_err_cycle", err_cyc - ref_cyc, TMO + 1);
    chk("tmo_code", int'(err_code), 6);
    ref_cyc = -1000;
    for (int k = 0; k < TMO + 100; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (!s_busy) begin
        ref_cyc = cyc;
        break;
      end
    end
    chk("tmo_drain_idle_cycle", ref_cyc - err_cyc, TMO + 1);
    chk("tmo_nerr", n_err, 1);
    chk("tmo_ndone", n_done, 0);

    // Asynchronous reset in the middle of a DATA0 packet.
    clr_mon();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("mid_count_before_rst", int'(data_count), 3);
    byte_complete = 1'b1;
    rx_byte = 8'h55;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", int'({busy, load_data, load_pid, load_done, load_error, crc_clear,
                                 crc_sel, enable_timer, pid, err_code, data_count}), 0);
    @(posedge clk);
    #1;
    byte_complete = 1'b0;
    rst = 1'b0;
    clr_mon();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_no_pulse", n_done + n_err, 0);
    chk("mid_rst_idle", int'(s_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
